serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor: computes operand_A - operand_B LSB-first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 8 +
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 70 +++++++
 tb/tb_serial_subtractor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding for the bit-serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit a - b - bin built from two half-subtractor stages
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);
  logic d1, b1, b2;
  assign d1   = a ^ b;
  assign b1   = ~a & b;
  assign diff = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first WIDTH-bit subtractor, one bit per clock through a single cell
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b, sh_d;
  logic [CW-1:0] cnt;
  logic bff, d, bout, load, last;
  full_subtractor u_fs (
    .diff(d),
    .bout(bout),
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .bin (bff)
  );
  assign load = start && state != ST_SHIFT;
  assign last = state == ST_SHIFT && cnt == CW'(WIDTH - 1);
  always_comb begin
    state_nx = ST_IDLE;
    busy     = 1'b0;
    done     = 1'b0;
    state_nx = load ? ST_SHIFT : state == ST_SHIFT ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
    busy     = state == ST_SHIFT;
    done     = state == ST_DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  end
  // results are only written on the edge that consumes the last bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a       <= '0;
      sh_b       <= '0;
      sh_d       <= '0;
      bff        <= 1'b0;
      cnt        <= '0;
      difference <= '0;
      borrow     <= 1'b0;
    end else if (load) begin
      sh_a <= operand_A;
      sh_b <= operand_B;
      bff  <= 1'b0;
      cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      sh_d <= {d, sh_d[WIDTH-1:1]};
      bff  <= bout;
      cnt  <= cnt + 1'b1;
      if (last) begin
        difference <= {d, sh_d[WIDTH-1:1]};
        borrow     <= bout;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH=4
module tb_serial_subtractor;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] op_a = '0, op_b = '0;
  logic [3:0] difference;
  logic borrow, busy, done;
  logic [4:0] q[$];
  int checks = 0, errors = 0;
  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand_A (op_a),
    .operand_B (op_b),
    .difference(difference),
    .borrow    (borrow),
    .busy      (busy),
    .done      (done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    logic ok;
    ok = (got === exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] dx;
    dx = a - b;
    return {dx, a < b};
  endfunction
  always @(negedge clk) begin
    logic [4:0] e;
    if (done) begin
      if (q.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        check("diff", difference, e[4:1]);
        check("borrow", borrow, e[0]);
      end
    end
  end
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end while (!done && n < 20);
    check("done_seen", done, 1);
  endtask
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit hold_chk, input bit lat_chk);
    int n, nb;
    logic [4:0] e;
    e = model(a, b);
    @(posedge clk);
    #1 start = 1'b1;
    op_a = a;
    op_b = b;
    q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    op_a = 4'($urandom);
    op_b = 4'($urandom);
    wait_done(n, nb);
    if (lat_chk) begin
      check("latency", n, 5);
      check("busy_cycles", nb, 4);
    end
    if (hold_chk) begin
      @(negedge clk);
      check("done_pulse", done, 0);
      @(negedge clk);
      check("held_diff", difference, e[4:1]);
      check("held_borrow", borrow, e[0]);
      check("idle", busy, 0);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, nb, seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_diff", difference, 0);
    check("rst_borrow", borrow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_op(4'd0, 4'd0, 1, 1);
    run_op(4'd9, 4'd3, 1, 1);
    run_op(4'd3, 4'd9, 1, 0);
    run_op(4'd0, 4'd1, 1, 0);
    run_op(4'd15, 4'd15, 1, 0);
    // start pulsed mid-shift with new operands must be ignored
    @(posedge clk);
    #1 start = 1'b1;
    op_a = 4'd9;
    op_b = 4'd3;
    q.push_back(model(4'd9, 4'd3));
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    op_a = 4'd0;
    op_b = 4'd15;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, nb);
    @(negedge clk);
    @(negedge clk);
    check("ign_diff", difference, 6);
    check("ign_borrow", borrow, 0);
    // start held through DONE chains a second op back-to-back
    @(posedge clk);
    #1 start = 1'b1;
    op_a = 4'd9;
    op_b = 4'd3;
    q.push_back(model(4'd9, 4'd3));
    q.push_back(model(4'd5, 4'd7));
    @(posedge clk);
    #1 op_a = 4'd5;
    op_b = 4'd7;
    wait_done(n, nb);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_prior_diff", difference, 6);
    check("b2b_prior_borrow", borrow, 0);
    wait_done(n, nb);
    @(negedge clk);
    // asynchronous reset mid-shift aborts without a done
    @(posedge clk);
    #1 start = 1'b1;
    op_a = 4'd9;
    op_b = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_diff", difference, 0);
    check("abort_borrow", borrow, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    run_op(4'd8, 4'd1, 1, 1);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b), 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
